// File: rtl/memory_io_unit_if.sv
// Bus bundle between the eLC-3 datapath, the memory_io_unit, the async SRAM control pins and the keyboard/display.
// SRAM_DQ is bidirectional, so it stays a plain inout port on the unit rather than living in this interface.
interface memory_io_unit_if;
  logic        MIO_EN;
  logic        R_W;
  logic [15:0] MAR;
  logic [15:0] MDR;
  logic [15:0] Mem_Out;
  logic        R;
  logic [15:0] SRAM_ADDR;
  logic        SRAM_CE_N;
  logic        SRAM_OE_N;
  logic        SRAM_WE_N;
  logic        KB_Valid;
  logic [7:0]  KB_Data;
  logic        Disp_Ready;
  logic        Disp_Valid;
  logic [7:0]  Disp_Data;

  modport master (
    output MIO_EN, R_W, MAR, MDR, KB_Valid, KB_Data, Disp_Ready,
    input  Mem_Out, R, SRAM_ADDR, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, Disp_Valid, Disp_Data
  );

  modport slave (
    input  MIO_EN, R_W, MAR, MDR, KB_Valid, KB_Data, Disp_Ready,
    output Mem_Out, R, SRAM_ADDR, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, Disp_Valid, Disp_Data
  );
endinterface

// File: rtl/memory_io_unit.sv
// eLC-3 memory access sequencer: async SRAM cycles with WAIT_STATES wait states, plus keyboard/display
// memory-mapped registers at xFE00 and above when ELC3_MMIO_EN is defined (otherwise everything goes to SRAM).
module memory_io_unit #(
  parameter int WAIT_STATES = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  memory_io_unit_if.slave  bus,
  inout  wire  [15:0]      SRAM_DQ
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  state_t      state, next_state;
  logic [15:0] addr_q;
  logic [15:0] data_q;
  logic        write_q;
  logic [3:0]  wait_cnt;
  logic [15:0] mem_out_q;
  logic        start;
  logic        mmio_hit;
  logic        mmio_read;
  logic        capture_sram;
  logic [15:0] mmio_rdata;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    start      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.MIO_EN) begin
          start      = 1'b1;
          next_state = mmio_hit ? DONE : ACCESS;
        end
      end
      ACCESS:  if (wait_cnt == 4'd0) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request fields are frozen at acceptance so the datapath may change MAR/MDR/R_W mid-access.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      addr_q   <= 16'h0000;
      data_q   <= 16'h0000;
      write_q  <= 1'b0;
      wait_cnt <= 4'd0;
    end else if (start) begin
      addr_q   <= bus.MAR;
      data_q   <= bus.MDR;
      write_q  <= bus.R_W;
      wait_cnt <= WAIT_INIT;
    end else if (state == ACCESS && wait_cnt != 4'd0) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  assign capture_sram = (state == ACCESS) && (wait_cnt == 4'd0) && !write_q;
  assign mmio_read    = start && mmio_hit && !bus.R_W;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)            mem_out_q <= 16'h0000;
    else if (capture_sram) mem_out_q <= SRAM_DQ;
    else if (mmio_read)    mem_out_q <= mmio_rdata;
  end

  assign bus.Mem_Out   = mem_out_q;
  assign bus.R         = (state == DONE);
  assign bus.SRAM_ADDR = addr_q;
  assign bus.SRAM_CE_N = (state != ACCESS);
  assign bus.SRAM_OE_N = !((state == ACCESS) && !write_q);
  assign bus.SRAM_WE_N = !((state == ACCESS) && write_q);
  assign SRAM_DQ       = ((state == ACCESS) && write_q) ? data_q : 16'hzzzz;

`ifdef ELC3_MMIO_EN
  logic       kb_ready;
  logic [7:0] kb_data;
  logic       disp_valid_q;
  logic [7:0] disp_data_q;
  logic       disp_write;

  assign mmio_hit   = (bus.MAR >= 16'hFE00);
  assign disp_write = start && mmio_hit && bus.R_W && (bus.MAR == 16'hFE06);

  always_comb begin
    mmio_rdata = 16'h0000;
    case (bus.MAR)
      16'hFE00: mmio_rdata = {kb_ready, 15'h0000};
      16'hFE02: mmio_rdata = {8'h00, kb_data};
      16'hFE04: mmio_rdata = {bus.Disp_Ready & ~disp_valid_q, 15'h0000};
      default:  mmio_rdata = 16'h0000;
    endcase
  end

  // A new keystroke wins over the clear from a simultaneous KBDR read; the read still sees the old byte.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      kb_ready <= 1'b0;
      kb_data  <= 8'h00;
    end else if (bus.KB_Valid) begin
      kb_ready <= 1'b1;
      kb_data  <= bus.KB_Data;
    end else if (mmio_read && bus.MAR == 16'hFE02) begin
      kb_ready <= 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      disp_valid_q <= 1'b0;
      disp_data_q  <= 8'h00;
    end else begin
      disp_valid_q <= disp_write;
      if (disp_write) disp_data_q <= bus.MDR[7:0];
    end
  end

  assign bus.Disp_Valid = disp_valid_q;
  assign bus.Disp_Data  = disp_data_q;
`else
  logic unused_mmio;

  assign mmio_hit       = 1'b0;
  assign mmio_rdata     = 16'h0000;
  assign bus.Disp_Valid = 1'b0;
  assign bus.Disp_Data  = 8'h00;
  assign unused_mmio    = ^{bus.KB_Valid, bus.KB_Data, bus.Disp_Ready};
`endif

endmodule

// File: tb/tb_memory_io_unit.sv
// Directed bench for memory_io_unit with a small async-SRAM model and a read-data scoreboard.
// Exercises the MMIO map when ELC3_MMIO_EN is defined, otherwise checks that xFE00+ goes to SRAM.
module tb_memory_io_unit;

  localparam int WS       = 1;
  localparam int SRAM_LAT = WS + 2;

  logic Clk   = 1'b0;
  logic Reset = 1'b0;
  wire  [15:0] SRAM_DQ;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_q[$];
  logic [15:0] last_read;
  logic [15:0] sram_mem [256];
  logic [15:0] sram_rd;

  always #5 Clk = ~Clk;

  memory_io_unit_if bus ();

  memory_io_unit #(.WAIT_STATES(WS)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .bus     (bus),
    .SRAM_DQ (SRAM_DQ)
  );

  // SRAM model folds the address to {addr[15:12], addr[3:0]} so the test addresses stay distinct.
  function automatic logic [7:0] sram_idx(input logic [15:0] a);
    return {a[15:12], a[3:0]};
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) sram_mem[i] <= 16'(i) ^ 16'hC300;
    sram_mem[8'h30] <= 16'h1234;
  end

  always_comb sram_rd = sram_mem[sram_idx(bus.SRAM_ADDR)];

  assign SRAM_DQ = (!bus.SRAM_CE_N && !bus.SRAM_OE_N && bus.SRAM_WE_N) ? sram_rd : 16'hzzzz;

  always @(posedge Clk) begin
    if (!bus.SRAM_CE_N && !bus.SRAM_WE_N) sram_mem[sram_idx(bus.SRAM_ADDR)] <= SRAM_DQ;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One complete transaction; expected read data goes through the scoreboard queue.
  task automatic applyStimulus(input logic wr, input logic [15:0] addr, input logic [15:0] data,
                               input logic [15:0] exp_read, input int exp_lat,
                               input logic disp_pulse, input logic kb_late);
    int          lat;
    logic [15:0] expv;
    lat = 0;
    if (!wr) exp_q.push_back(exp_read);
    @(negedge Clk);
    bus.MIO_EN = 1'b1;
    bus.R_W    = wr;
    bus.MAR    = addr;
    bus.MDR    = data;
    for (int c = 1; c <= 64 && lat == 0; c++) begin
      @(negedge Clk);
      if (c == 1) begin
        bus.MIO_EN = 1'b0;
        bus.MAR    = ~addr;
        bus.MDR    = ~data;
        bus.R_W    = ~wr;
        if (kb_late) begin
          bus.KB_Valid = 1'b1;
          bus.KB_Data  = 8'h42;
        end
      end else begin
        bus.KB_Valid = 1'b0;
      end
      checkOutput("disp_valid", 32'(bus.Disp_Valid), 32'(disp_pulse && c == 1));
      if (exp_lat > 1 && c < exp_lat) begin
        checkOutput("ce_n_access", 32'(bus.SRAM_CE_N), 32'd0);
        checkOutput("oe_n_access", 32'(bus.SRAM_OE_N), 32'(wr));
        checkOutput("we_n_access", 32'(bus.SRAM_WE_N), 32'(!wr));
        checkOutput("sram_addr", 32'(bus.SRAM_ADDR), 32'(addr));
        if (wr) checkOutput("dq_write", 32'(SRAM_DQ), 32'(data));
      end
      if (bus.R) lat = c;
    end
    checkOutput("latency", 32'(lat), 32'(exp_lat));
    checkOutput("strobes_done", 32'({bus.SRAM_CE_N, bus.SRAM_OE_N, bus.SRAM_WE_N}), 32'h7);
    if (!wr) begin
      expv = exp_q.pop_front();
      checkOutput("mem_out_read", 32'(bus.Mem_Out), 32'(expv));
      last_read = expv;
    end else begin
      checkOutput("mem_out_hold", 32'(bus.Mem_Out), 32'(last_read));
    end
    @(negedge Clk);
    bus.KB_Valid = 1'b0;
    checkOutput("r_pulse_width", 32'(bus.R), 32'd0);
    checkOutput("disp_valid_after", 32'(bus.Disp_Valid), 32'd0);
  endtask

  task automatic pulseKb(input logic [7:0] b);
    @(negedge Clk);
    bus.KB_Valid = 1'b1;
    bus.KB_Data  = b;
    @(negedge Clk);
    bus.KB_Valid = 1'b0;
  endtask

  initial begin
    bus.MIO_EN     = 1'b0;
    bus.R_W        = 1'b0;
    bus.MAR        = 16'h0000;
    bus.MDR        = 16'h0000;
    bus.KB_Valid   = 1'b0;
    bus.KB_Data    = 8'h00;
    bus.Disp_Ready = 1'b0;
    last_read      = 16'h0000;

    repeat (3) @(negedge Clk);
    checkOutput("rst_mem_out", 32'(bus.Mem_Out), 32'h0);
    checkOutput("rst_r", 32'(bus.R), 32'h0);
    checkOutput("rst_strobes", 32'({bus.SRAM_CE_N, bus.SRAM_OE_N, bus.SRAM_WE_N}), 32'h7);
    checkOutput("rst_sram_addr", 32'(bus.SRAM_ADDR), 32'h0);
    checkOutput("rst_disp_valid", 32'(bus.Disp_Valid), 32'h0);
    checkOutput("rst_disp_data", 32'(bus.Disp_Data), 32'h0);
    Reset = 1'b1;

    applyStimulus(1'b0, 16'h3000, 16'h0000, 16'h1234, SRAM_LAT, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h4000, 16'hBEEF, 16'h0000, SRAM_LAT, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h4000, 16'h0000, 16'hBEEF, SRAM_LAT, 1'b0, 1'b0);

`ifdef ELC3_MMIO_EN
    $display("[TB] MMIO build");
    pulseKb(8'h41);
    applyStimulus(1'b0, 16'hFE00, 16'h0000, 16'h8000, 1, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'hFE02, 16'h0000, 16'h0041, 1, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'hFE00, 16'h0000, 16'h0000, 1, 1'b0, 1'b0);
    pulseKb(8'h41);
    applyStimulus(1'b0, 16'hFE02, 16'h0000, 16'h0041, 1, 1'b0, 1'b1);
    applyStimulus(1'b0, 16'hFE00, 16'h0000, 16'h8000, 1, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'hFE02, 16'h0000, 16'h0042, 1, 1'b0, 1'b0);
    bus.Disp_Ready = 1'b1;
    applyStimulus(1'b1, 16'hFE06, 16'h0158, 16'h0000, 1, 1'b1, 1'b0);
    checkOutput("disp_data_hold", 32'(bus.Disp_Data), 32'h58);
    applyStimulus(1'b0, 16'hFE04, 16'h0000, 16'h8000, 1, 1'b0, 1'b0);
    bus.Disp_Ready = 1'b0;
    applyStimulus(1'b0, 16'hFE04, 16'h0000, 16'h0000, 1, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hFE00, 16'hFFFF, 16'h0000, 1, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'hFE00, 16'h0000, 16'h0000, 1, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'hFF10, 16'h0000, 16'h0000, 1, 1'b0, 1'b0);
`else
    $display("[TB] SRAM-only build");
    pulseKb(8'h41);
    applyStimulus(1'b0, 16'hFE00, 16'h0000, 16'hC3F0, SRAM_LAT, 1'b0, 1'b0);
    bus.Disp_Ready = 1'b1;
    applyStimulus(1'b1, 16'hFE06, 16'h0158, 16'h0000, SRAM_LAT, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'hFE06, 16'h0000, 16'h0158, SRAM_LAT, 1'b0, 1'b0);
    checkOutput("disp_data_tied", 32'(bus.Disp_Data), 32'h0);
`endif

    // Abort a read in its first ACCESS cycle.
    @(negedge Clk);
    bus.MIO_EN = 1'b1;
    bus.R_W    = 1'b0;
    bus.MAR    = 16'h3000;
    @(negedge Clk);
    bus.MIO_EN = 1'b0;
    checkOutput("abort_ce_before", 32'(bus.SRAM_CE_N), 32'h0);
    Reset = 1'b0;
    #1;
    checkOutput("abort_strobes", 32'({bus.SRAM_CE_N, bus.SRAM_OE_N, bus.SRAM_WE_N}), 32'h7);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      checkOutput("abort_no_r", 32'(bus.R), 32'h0);
    end
    checkOutput("abort_mem_out", 32'(bus.Mem_Out), 32'h0);
    last_read = 16'h0000;
    Reset = 1'b1;
    applyStimulus(1'b0, 16'h3000, 16'h0000, 16'h1234, SRAM_LAT, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_io_unit.md
# memory_io_unit

Memory access sequencer between the eLC-3 datapath and the outside world. It services the datapath's MIO_EN/R_W requests using MAR as the address and MDR as the write data. Each request is turned into an asynchronous-SRAM cycle with programmable wait states, or into an access to the keyboard/display memory-mapped registers. Read data returns to the MDR input mux, and a one-cycle ready pulse R goes back to the control FSM.

## Interface
Parameters:
- WAIT_STATES, 1: extra SRAM cycles per access; legal range 0–15.

Ports:
- Clk  in  1  system clock; all state on rising edge
- Reset  in  1  asynchronous, active-low reset
- MIO_EN  in  1  memory request from control FSM
- R_W  in  1  1 = write, 0 = read; sampled with request
- MAR  in  16  access address; sampled with request
- MDR  in  16  write data; sampled with request
- Mem_Out  out  16  registered read data to MDR mux
- R  out  1  access-complete pulse to control FSM
- SRAM_ADDR  out  16  SRAM address
- SRAM_DQ  inout  16  SRAM data; driven only during write ACCESS cycles, else Z
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N  out  1 each  active-low SRAM strobes
- KB_Valid  in  1  one-cycle keyboard strobe
- KB_Data  in  8  keyboard byte
- Disp_Ready  in  1  display can accept a byte
- Disp_Valid  out  1  one-cycle display strobe
- Disp_Data  out  8  display byte

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - MIO_EN=1 latches MAR, MDR and R_W.
  - If MMIO is compiled in and address ≥ xFE00, go to DONE.
  - Otherwise go to ACCESS and load the wait counter with WAIT_STATES.
- ACCESS:
  - CE_N=0 and ADDR=latched address.
  - Read: OE_N=0.
  - Write: WE_N=0 and DQ driven with latched data.
  - Counter decrements each cycle; at 0, a read captures SRAM_DQ into Mem_Out and the FSM goes to DONE.
- DONE: R=1 for exactly one cycle; all strobes inactive; next state IDLE.
  - If MIO_EN is still 1 in the following IDLE cycle, a new access starts (back-to-back permitted).
- Mem_Out changes only on read completion and holds otherwise; writes never alter it.
- MIO_EN is ignored outside IDLE. Changes to MAR/MDR/R_W mid-access have no effect.
- MMIO map:
  - xFE00 KBSR: bit15 = kb_ready, others 0.
  - xFE02 KBDR: {8'h00, kb_data}.
  - xFE04 DSR: bit15 = Disp_Ready & ~Disp_Valid, others 0.
  - xFE06 DDR: reads x0000.
  - xFE08–xFFFF: read x0000; writes dropped.
- Keyboard:
  - KB_Valid=1 loads kb_data and sets kb_ready. Overrun overwrites data and kb_ready stays 1.
  - A completed KBDR read clears kb_ready.
  - If KB_Valid coincides with the KBDR-read completion cycle, the new byte is stored and kb_ready stays 1. The read returns the old byte.
- Display:
  - A write to DDR pulses Disp_Valid for one cycle (the DONE cycle) with Disp_Data = MDR[7:0].
  - Disp_Data holds afterwards.
  - The write is issued regardless of Disp_Ready; software polls DSR.
- Writes to KBSR, KBDR and DSR are ignored.

## Timing
- Cycle 0 is the IDLE cycle in which MIO_EN=1.
- SRAM access:
  - ACCESS occupies cycles 1..WAIT_STATES+1.
  - R=1 in cycle WAIT_STATES+2.
  - Mem_Out is valid from that same cycle.
  - Default total latency is 3 cycles from request to R.
- MMIO access: R=1 in cycle 1. Mem_Out and Disp_Valid update in cycle 1.
- Reset values:
  - Outputs: Mem_Out=x0000, R=0; CE_N/OE_N/WE_N=1; SRAM_ADDR=x0000; DQ=Z; Disp_Valid=0; Disp_Data=x00.
  - Internal: kb_ready=0, kb_data=x00, FSM=IDLE.
- Reset asserted mid-access aborts immediately. Strobes go inactive asynchronously and no R is issued.

## Configuration
- ELC3_MMIO_EN defined: MMIO decode, keyboard and display logic present as described.
- ELC3_MMIO_EN undefined:
  - Every address, including xFE00–xFFFF, goes to SRAM.
  - KB_* inputs are ignored.
  - Disp_Valid is tied 0 and Disp_Data is tied x00.

## Test plan
- SRAM read, WAIT_STATES=1: MAR=x3000 and SRAM model returns x1234 -> OE_N/CE_N low in cycles 1–2; R=1 only in cycle 3; Mem_Out=x1234.
- SRAM write: MAR=x4000, MDR=xBEEF, R_W=1 -> WE_N low in cycles 1–2 with DQ=xBEEF; R in cycle 3; Mem_Out unchanged; DQ=Z in cycle 3.
- Keyboard:
  - KB_Valid with x41, then read xFE00 -> x8000.
  - Read xFE02 -> x0041 and R in cycle 1.
  - Reread xFE00 -> x0000.
- Coincident keyboard event: KB_Valid with x42 in the completion cycle of a KBDR read -> read returns old byte; next KBSR read gives x8000 and KBDR gives x0042.
- Display: Disp_Ready=1; write x0158 to xFE06 -> Disp_Valid pulses for one cycle with Disp_Data=x58; DSR read in that cycle returns x0000, afterwards x8000.
- Reset mid-ACCESS: assert Reset in cycle 1 of a read -> strobes immediately high; no R; after release, a new read completes normally. Repeat with ELC3_MMIO_EN undefined: a read of xFE00 goes to SRAM with 3-cycle latency.
